// File: rtl/cnn_acc_pkg.sv
// Shared definitions for the CNN accelerator DRAM-side blocks.
// Provides the DRAM address/data widths and the arbiter state encoding.
package cnn_acc_pkg;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } arb_state_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO holding posted writes ({addr, data} words).
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   push, push_data - enqueue a word (ignored when full)
//   pop             - dequeue the head word (ignored when empty)
//   head            - current head word (meaningless when empty)
//   full, empty     - occupancy flags
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 74
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [PTR_W:0]   r_wptr;
    logic [PTR_W:0]   r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_wptr == r_rptr);
    assign full      = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                       (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign head      = r_mem[r_rptr[PTR_W-1:0]];

    // Pointer update and storage write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= {(PTR_W+1){1'b0}};
            r_rptr <= {(PTR_W+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr[PTR_W-1:0]] <= push_data;
                r_wptr <= r_wptr + {{PTR_W{1'b0}}, 1'b1};
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + {{PTR_W{1'b0}}, 1'b1};
            end
        end
    end
endmodule

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: single-port DRAM scheduler between the ifmap fetch
// engine (reads) and the max-pool writeback engine (posted writes).
// One DRAM access is issued per cycle from registered command outputs.
// Ports:
//   clk, rst_n, start        - clock, async active-low reset, layer start pulse
//   rd_req/rd_addr/rd_gnt    - read request, address, combinational grant
//   rd_valid/rd_data         - read return, two cycles after the grant
//   wr_req/wr_addr/wr_data   - write post; accepted when wr_ready
//   DRAMreadData             - DRAM read return (driven during the command cycle)
//   DRAMread*/DRAMwrite*     - registered DRAM command bus
//   done                     - sticky layer-complete flag
module dram_port_arbiter #(
    parameter int ADDR_W     = cnn_acc_pkg::ADDR_W,
    parameter int DATA_W     = cnn_acc_pkg::DATA_W,
    parameter int WBUF_DEPTH = 4,
    parameter int STARVE_MAX = 8,
    parameter int LAST_WADDR = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] DRAMreadData,
    output logic              DRAMreadEn,
    output logic [ADDR_W-1:0] DRAMreadAddr,
    output logic              DRAMwriteEn,
    output logic [ADDR_W-1:0] DRAMwriteAddr,
    output logic [DATA_W-1:0] DRAMwriteData,
    output logic              done
);
    import cnn_acc_pkg::*;

    localparam int WORD_W = ADDR_W + DATA_W;
    localparam int SC_W   = $clog2(STARVE_MAX + 1);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [SC_W-1:0]   r_starve_cnt;
    logic              r_done;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_dram_ren;
    logic [ADDR_W-1:0] r_dram_raddr;
    logic              r_dram_wen;
    logic [ADDR_W-1:0] r_dram_waddr;
    logic [DATA_W-1:0] r_dram_wdata;

    logic              w_run;
    logic              w_rd_want;
    logic              w_push;
    logic              w_pending;
    logic              w_starved;
    logic              w_wr_sel;
    logic              w_rd_sel;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_fifo_push;
    logic              w_fifo_pop;
    logic [WORD_W-1:0] w_fifo_head;
    logic [WORD_W-1:0] w_wr_word;
    logic              w_last_on_bus;

    assign w_run     = (r_state == RUN);
    // Outside RUN reads are never granted, so they must not hold writes back.
    assign w_rd_want = rd_req && w_run;
    assign wr_ready  = w_run && !w_fifo_full;
    assign w_push    = wr_req && wr_ready;
    assign w_starved = (r_starve_cnt == SC_W'(STARVE_MAX));

    // A word being posted this cycle counts as pending: with an empty buffer it
    // bypasses storage and reaches the DRAM bus on the next cycle.
    assign w_pending = !w_fifo_empty || w_push;
    assign w_wr_sel  = w_pending && (!w_rd_want || w_fifo_full || w_starved);
    assign w_rd_sel  = w_rd_want && !w_wr_sel;
    assign rd_gnt    = w_rd_sel;

    assign w_wr_word   = w_fifo_empty ? {wr_addr, wr_data} : w_fifo_head;
    assign w_fifo_push = w_push && !(w_wr_sel && w_fifo_empty);
    assign w_fifo_pop  = w_wr_sel && !w_fifo_empty;

    assign w_last_on_bus = r_dram_wen && (r_dram_waddr == ADDR_W'(LAST_WADDR));

    wb_fifo #(
        .DEPTH (WBUF_DEPTH),
        .WIDTH (WORD_W)
    ) u_wb_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_fifo_push),
        .push_data ({wr_addr, wr_data}),
        .pop       (w_fifo_pop),
        .head      (w_fifo_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    // Layer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Layer next-state logic; the layer ends once its last word is on the bus.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = start ? RUN : IDLE;
            RUN:     w_state_nxt = w_last_on_bus ? DONE : RUN;
            DONE:    w_state_nxt = start ? RUN : DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Sticky done flag tracks entry into DONE; start leaves DONE and clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (w_state_nxt == DONE);
        end
    end

    // Starvation counter: read grants taken while a write is waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= {SC_W{1'b0}};
        end else if (w_wr_sel) begin
            r_starve_cnt <= {SC_W{1'b0}};
        end else if (w_rd_sel && w_pending && !w_starved) begin
            r_starve_cnt <= r_starve_cnt + SC_W'(1);
        end else begin
            r_starve_cnt <= r_starve_cnt;
        end
    end

    // DRAM command registers: enables pulse, address/data hold between uses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dram_ren   <= 1'b0;
            r_dram_raddr <= {ADDR_W{1'b0}};
            r_dram_wen   <= 1'b0;
            r_dram_waddr <= {ADDR_W{1'b0}};
            r_dram_wdata <= {DATA_W{1'b0}};
        end else begin
            r_dram_ren <= w_rd_sel;
            r_dram_wen <= w_wr_sel;
            if (w_rd_sel) begin
                r_dram_raddr <= rd_addr;
            end
            if (w_wr_sel) begin
                r_dram_waddr <= w_wr_word[WORD_W-1:DATA_W];
                r_dram_wdata <= w_wr_word[DATA_W-1:0];
            end
        end
    end

    // Read return: DRAM data is captured at the end of the command cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= {DATA_W{1'b0}};
        end else begin
            r_rd_valid <= r_dram_ren;
            if (r_dram_ren) begin
                r_rd_data <= DRAMreadData;
            end
        end
    end

    assign rd_valid      = r_rd_valid;
    assign rd_data       = r_rd_data;
    assign DRAMreadEn    = r_dram_ren;
    assign DRAMreadAddr  = r_dram_raddr;
    assign DRAMwriteEn   = r_dram_wen;
    assign DRAMwriteAddr = r_dram_waddr;
    assign DRAMwriteData = r_dram_wdata;
    assign done          = r_done;
endmodule

// File: tb/tb_dram_port_arbiter.sv
// Self-checking bench for dram_port_arbiter: directed scenarios plus a
// randomized run checked against a queue-based reference model.
module tb_dram_port_arbiter;
    localparam int AW    = 10;
    localparam int DW    = 64;
    localparam int DEPTH = 4;
    localparam int SMAX  = 8;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } went_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] DRAMreadData = '0;
    logic          rd_gnt, rd_valid, wr_ready, DRAMreadEn, DRAMwriteEn, done;
    logic [DW-1:0] rd_data, DRAMwriteData;
    logic [AW-1:0] DRAMreadAddr, DRAMwriteAddr;

    int total = 0;
    int bad   = 0;

    dram_port_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_gnt        (rd_gnt),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .wr_req        (wr_req),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .DRAMreadData  (DRAMreadData),
        .DRAMreadEn    (DRAMreadEn),
        .DRAMreadAddr  (DRAMreadAddr),
        .DRAMwriteEn   (DRAMwriteEn),
        .DRAMwriteAddr (DRAMwriteAddr),
        .DRAMwriteData (DRAMwriteData),
        .done          (done)
    );

    always #5 clk = ~clk;

    // DRAM contents: mem[a] = 0xA0 ^ a, so mem[5] = 0xA5.
    function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
        return 64'h0000_0000_0000_00A0 ^ {54'd0, a};
    endfunction

    // DRAM model drives read data on the negedge of the command cycle.
    always @(negedge clk) begin
        if (DRAMreadEn) DRAMreadData <= memval(DRAMreadAddr);
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rd_req = 1'b1; wr_req = 1'b1; rd_addr = 10'd7; wr_addr = 10'd7;
        @(negedge clk); #1;
        total++;
        if ({rd_gnt, rd_valid, wr_ready, DRAMreadEn, DRAMwriteEn, done} !== 6'b0) begin
            bad++; $display("FAIL reset_flags got=%b exp=000000",
                {rd_gnt, rd_valid, wr_ready, DRAMreadEn, DRAMwriteEn, done});
        end
        total++;
        if ({rd_data, DRAMreadAddr, DRAMwriteAddr, DRAMwriteData} !== 148'd0) begin
            bad++; $display("FAIL reset_buses got rd_data=%h ra=%0d wa=%0d wd=%h exp all 0",
                rd_data, DRAMreadAddr, DRAMwriteAddr, DRAMwriteData);
        end
        @(negedge clk); rst_n = 1'b1; #1;
        total++;
        if (rd_gnt !== 1'b0 || wr_ready !== 1'b0) begin
            bad++; $display("FAIL idle_block got gnt=%b ready=%b exp 0 0", rd_gnt, wr_ready);
        end
        @(negedge clk); #1;
        total++;
        if (DRAMreadEn !== 1'b0 || DRAMwriteEn !== 1'b0) begin
            bad++; $display("FAIL idle_no_issue got ren=%b wen=%b exp 0 0", DRAMreadEn, DRAMwriteEn);
        end
        rd_req = 1'b0; wr_req = 1'b0;
    endtask

    task automatic test_read();
        do_reset(); pulse_start();
        rd_req = 1'b1; rd_addr = 10'd5; #1;
        total++;
        if (rd_gnt !== 1'b1) begin bad++; $display("FAIL read_gnt got=%b exp=1", rd_gnt); end
        @(negedge clk); rd_req = 1'b0; #1;
        total++;
        if (DRAMreadEn !== 1'b1 || DRAMreadAddr !== 10'd5 || rd_valid !== 1'b0) begin
            bad++; $display("FAIL read_cmd got en=%b addr=%0d valid=%b exp 1 5 0",
                DRAMreadEn, DRAMreadAddr, rd_valid);
        end
        @(negedge clk); #1;
        total++;
        if (rd_valid !== 1'b1 || rd_data !== 64'hA5 || DRAMreadEn !== 1'b0) begin
            bad++; $display("FAIL read_data got valid=%b data=%h en=%b exp 1 a5 0",
                rd_valid, rd_data, DRAMreadEn);
        end
        @(negedge clk); #1;
        total++;
        if (rd_valid !== 1'b0) begin bad++; $display("FAIL read_pulse got=%b exp=0", rd_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset(); pulse_start();
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            rd_req = (i < 5); rd_addr = AW'(100 + i); #1;
            if (i < 5) begin
                total++;
                if (rd_gnt !== 1'b1) begin bad++; $display("FAIL b2b_gnt[%0d] got=%b exp=1", i, rd_gnt); end
            end
            if (i >= 2) begin
                total++;
                if (rd_valid !== 1'b1 || rd_data !== memval(AW'(98 + i))) begin
                    bad++; $display("FAIL b2b_data[%0d] got valid=%b data=%h exp 1 %h",
                        i, rd_valid, rd_data, memval(AW'(98 + i)));
                end
            end
        end
        rd_req = 1'b0;
    endtask

    task automatic test_starve();
        int g;
        do_reset(); pulse_start();
        rd_req = 1'b1; rd_addr = 10'd50;
        wr_req = 1'b1; wr_addr = 10'd3; wr_data = 64'hDEAD_BEEF_0000_0003; #1;
        g = 0;
        if (rd_gnt === 1'b1) g++;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk); wr_req = 1'b0; rd_addr = AW'(50 + c); #1;
            if (rd_gnt === 1'b1) g++;
        end
        total++;
        if (g !== 8) begin bad++; $display("FAIL starve_reads got=%0d exp=8", g); end
        @(negedge clk); #1;
        total++;
        if (rd_gnt !== 1'b0) begin bad++; $display("FAIL starve_force got gnt=%b exp=0", rd_gnt); end
        @(negedge clk); #1;
        total++;
        if (DRAMwriteEn !== 1'b1 || DRAMwriteAddr !== 10'd3 ||
            DRAMwriteData !== 64'hDEAD_BEEF_0000_0003 || DRAMreadEn !== 1'b0) begin
            bad++; $display("FAIL starve_write got wen=%b wa=%0d wd=%h ren=%b exp 1 3 deadbeef00000003 0",
                DRAMwriteEn, DRAMwriteAddr, DRAMwriteData, DRAMreadEn);
        end
        total++;
        if (rd_gnt !== 1'b1) begin bad++; $display("FAIL starve_resume got gnt=%b exp=1", rd_gnt); end
        rd_req = 1'b0;
    endtask

    task automatic test_full();
        logic [AW-1:0] seen[$];
        logic [4:0]    ready_bits;
        int            pushed;
        do_reset(); pulse_start();
        rd_req = 1'b1; rd_addr = 10'd200; pushed = 0; ready_bits = 5'd0;
        for (int c = 0; c < 120 && seen.size() < 5; c++) begin
            if (c > 0) @(negedge clk);
            wr_req  = (pushed < 5);
            wr_addr = AW'(10 + pushed);
            wr_data = 64'hC0DE_0000_0000_0000 | {54'd0, wr_addr};
            #1;
            if (c < 5) ready_bits[c] = wr_ready;
            if (c == 4) begin
                total++;
                if (rd_gnt !== 1'b0) begin bad++; $display("FAIL full_force got gnt=%b exp=0", rd_gnt); end
            end
            total++;
            if (DRAMwriteEn && DRAMreadEn) begin
                bad++; $display("FAIL full_excl got both enables exp one");
            end
            if (DRAMwriteEn === 1'b1) begin
                total++;
                if (DRAMwriteData !== (64'hC0DE_0000_0000_0000 | {54'd0, DRAMwriteAddr})) begin
                    bad++; $display("FAIL full_wdata got=%h for addr %0d", DRAMwriteData, DRAMwriteAddr);
                end
                seen.push_back(DRAMwriteAddr);
            end
            if (wr_req && wr_ready) pushed++;
        end
        wr_req = 1'b0; rd_req = 1'b0;
        total++;
        if (ready_bits !== 5'b01111) begin
            bad++; $display("FAIL full_ready got=%b exp=01111 (bit0 first)", ready_bits);
        end
        total++;
        if (seen.size() !== 5) begin
            bad++; $display("FAIL full_count got=%0d exp=5", seen.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (seen[i] !== AW'(10 + i)) begin
                    bad++; $display("FAIL full_order[%0d] got=%0d exp=%0d", i, seen[i], 10 + i);
                end
            end
        end
    endtask

    task automatic test_done();
        do_reset(); pulse_start();
        rd_req = 1'b0;
        for (int a = 0; a <= 25; a++) begin
            if (a > 0) @(negedge clk);
            wr_req = (a <= 24); wr_addr = AW'(a); wr_data = 64'h5000 + 64'(a); #1;
            if (a <= 24) begin
                total++;
                if (wr_ready !== 1'b1) begin bad++; $display("FAIL done_ready[%0d] got=%b exp=1", a, wr_ready); end
            end
            if (a >= 1) begin
                total++;
                if (DRAMwriteEn !== 1'b1 || DRAMwriteAddr !== AW'(a - 1) ||
                    DRAMwriteData !== 64'h5000 + 64'(a - 1)) begin
                    bad++; $display("FAIL done_stream[%0d] got wen=%b wa=%0d wd=%h exp 1 %0d %h",
                        a, DRAMwriteEn, DRAMwriteAddr, DRAMwriteData, a - 1, 64'h5000 + 64'(a - 1));
                end
            end
            total++;
            if (done !== 1'b0) begin bad++; $display("FAIL done_early[%0d] got=%b exp=0", a, done); end
        end
        @(negedge clk); rd_req = 1'b1; wr_req = 1'b1; #1;
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL done_set got=%b exp=1", done); end
        total++;
        if (rd_gnt !== 1'b0 || wr_ready !== 1'b0) begin
            bad++; $display("FAIL done_block got gnt=%b ready=%b exp 0 0", rd_gnt, wr_ready);
        end
        @(negedge clk); #1;
        total++;
        if (done !== 1'b1 || DRAMreadEn !== 1'b0) begin
            bad++; $display("FAIL done_sticky got done=%b ren=%b exp 1 0", done, DRAMreadEn);
        end
        rd_req = 1'b0; wr_req = 1'b0;
        pulse_start(); #1;
        total++;
        if (done !== 1'b0 || wr_ready !== 1'b1) begin
            bad++; $display("FAIL done_clear got done=%b ready=%b exp 0 1", done, wr_ready);
        end
    endtask

    task automatic test_reset_mid();
        int wseen, vseen;
        do_reset(); pulse_start();
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            rd_req = 1'b1; rd_addr = AW'(300 + c);
            wr_req = (c < 3); wr_addr = AW'(600 + c); wr_data = 64'h7700 + 64'(c); #1;
            total++;
            if (rd_gnt !== 1'b1) begin bad++; $display("FAIL rstmid_gnt[%0d] got=%b exp=1", c, rd_gnt); end
        end
        @(negedge clk); rd_req = 1'b0; wr_req = 1'b0; rst_n = 1'b0; #1;
        total++;
        if ({rd_gnt, rd_valid, wr_ready, DRAMreadEn, DRAMwriteEn, done} !== 6'b0 ||
            {rd_data, DRAMreadAddr, DRAMwriteAddr, DRAMwriteData} !== 148'd0) begin
            bad++; $display("FAIL rstmid_zero got flags=%b ra=%0d wa=%0d exp all 0",
                {rd_gnt, rd_valid, wr_ready, DRAMreadEn, DRAMwriteEn, done}, DRAMreadAddr, DRAMwriteAddr);
        end
        @(negedge clk); #1;
        total++;
        if (rd_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", rd_valid); end
        @(negedge clk); rst_n = 1'b1;
        pulse_start();
        wseen = 0; vseen = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (DRAMwriteEn === 1'b1) wseen++;
            if (rd_valid === 1'b1) vseen++;
            @(negedge clk);
        end
        total++;
        if (wseen !== 0 || vseen !== 0) begin
            bad++; $display("FAIL rstmid_after got writes=%0d valids=%0d exp 0 0", wseen, vseen);
        end
    endtask

    task automatic test_random();
        went_t         pend[$];
        went_t         exp_w;
        bit            exp_wen, exp_ren, exp_rv, was_full, e_ready, wsel, e_gnt;
        logic [AW-1:0] exp_ra, exp_ra2;
        int            starve, base;
        exp_wen = 1'b0; exp_ren = 1'b0; exp_rv = 1'b0; exp_w = '0;
        exp_ra = '0; exp_ra2 = '0; starve = 0; base = bad;
        do_reset(); pulse_start();
        for (int c = 0; c < 10000 && (bad - base) < 50; c++) begin
            if (c > 0) @(negedge clk);
            rd_req  = ($urandom_range(99) < 70);
            rd_addr = AW'($urandom);
            wr_req  = ($urandom_range(1) == 1);
            wr_addr = AW'($urandom_range(1023, 100));
            wr_data = {$urandom, $urandom};
            #1;
            total++;
            if (DRAMreadEn === 1'b1 && DRAMwriteEn === 1'b1) begin
                bad++; $display("FAIL rnd_excl[%0d] got both enables exp one", c);
            end
            total++;
            if (DRAMwriteEn !== exp_wen || (exp_wen && {DRAMwriteAddr, DRAMwriteData} !== exp_w)) begin
                bad++; $display("FAIL rnd_write[%0d] got en=%b a=%0d d=%h exp en=%b a=%0d d=%h",
                    c, DRAMwriteEn, DRAMwriteAddr, DRAMwriteData, exp_wen, exp_w.a, exp_w.d);
            end
            total++;
            if (DRAMreadEn !== exp_ren || (exp_ren && DRAMreadAddr !== exp_ra)) begin
                bad++; $display("FAIL rnd_rcmd[%0d] got en=%b a=%0d exp en=%b a=%0d",
                    c, DRAMreadEn, DRAMreadAddr, exp_ren, exp_ra);
            end
            total++;
            if (rd_valid !== exp_rv || (exp_rv && rd_data !== memval(exp_ra2))) begin
                bad++; $display("FAIL rnd_rdata[%0d] got v=%b d=%h exp v=%b d=%h",
                    c, rd_valid, rd_data, exp_rv, memval(exp_ra2));
            end
            was_full = (pend.size() == DEPTH);
            e_ready  = (pend.size() < DEPTH);
            total++;
            if (wr_ready !== e_ready) begin
                bad++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", c, wr_ready, e_ready);
            end
            if (wr_req && e_ready) pend.push_back('{a: wr_addr, d: wr_data});
            wsel  = (pend.size() > 0) && (!rd_req || was_full || starve == SMAX);
            e_gnt = !wsel && rd_req;
            total++;
            if (rd_gnt !== e_gnt) begin
                bad++; $display("FAIL rnd_gnt[%0d] got=%b exp=%b", c, rd_gnt, e_gnt);
            end
            exp_rv  = exp_ren;
            exp_ra2 = exp_ra;
            exp_ren = e_gnt;
            exp_ra  = rd_addr;
            exp_wen = wsel;
            if (wsel) begin
                exp_w  = pend.pop_front();
                starve = 0;
            end else if (e_gnt && pend.size() > 0 && starve < SMAX) begin
                starve++;
            end
        end
        rd_req = 1'b0; wr_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read();
        test_back_to_back();
        test_starve();
        test_full();
        test_done();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dram_port_arbiter.md
# dram_port_arbiter

Single-port DRAM scheduler between the accelerator's ifmap fetch engine (read requester) and the max-pool writeback engine (write requester). Posted writes sit in a small buffer; each cycle it issues exactly one DRAM access, reads or writes, and drives the shared `DRAMreadEn/DRAMreadAddr/DRAMwriteEn/DRAMwriteAddr/DRAMwriteData` bus from registers. It also tracks layer completion: `done` is raised once the last pooled word is written. It sits inside `Top`, between the PE-array control and the external DRAM interface.

## Interface
- `ADDR_W`, 10, DRAM word-address width
- `DATA_W`, 64, DRAM word width
- `WBUF_DEPTH`, 4, write-buffer entries (power of 2, ≥2)
- `STARVE_MAX`, 8, consecutive read grants allowed while writes are pending
- `LAST_WADDR`, 24, write address that completes a layer (25 words = 196 pooled bytes, padded)

Ports:
- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `start` in 1: one-cycle pulse, begin a layer
- `rd_req` in 1: fetch engine requests a read
- `rd_addr` in ADDR_W: read address, valid with `rd_req`
- `rd_gnt` out 1: combinational; read accepted this cycle
- `rd_valid` out 1: registered; `rd_data` valid this cycle
- `rd_data` out DATA_W: returned word
- `wr_req` in 1: writeback engine posts a write
- `wr_addr` in ADDR_W / `wr_data` in DATA_W: write payload
- `wr_ready` out 1: buffer can accept this cycle
- `DRAMreadData` in DATA_W: DRAM read return (`ifmap`)
- `DRAMreadEn`, `DRAMwriteEn` out 1; `DRAMreadAddr`, `DRAMwriteAddr` out ADDR_W; `DRAMwriteData` out DATA_W: registered DRAM command
- `done` out 1: sticky, layer complete

## Operation
- FSM: IDLE → RUN on `start`; RUN → DONE when a write to `LAST_WADDR` is issued; DONE → RUN on `start`. `start` in RUN is ignored.
- IDLE/DONE: `rd_gnt`=0 and `wr_ready`=0. Buffered writes still drain in DONE.
- RUN: `wr_ready` = buffer not full. A push occurs when `wr_req && wr_ready`. Push and pop can happen in the same cycle. When the buffer is full, `wr_ready` stays 0 even on a pop cycle.
- One issue per cycle. Select a write when the buffer is non-empty and (`!rd_req` or buffer full or `starve_cnt`==`STARVE_MAX`). Otherwise select a read when `rd_req` is set in RUN. `rd_gnt` = read selected.
- `starve_cnt`: increments on each read grant while the buffer is non-empty, saturating at `STARVE_MAX`. Cleared on every write issue.
- Writes issue in FIFO order. The DRAM never sees `DRAMreadEn` and `DRAMwriteEn` high together.
- `done` sets the cycle after the `LAST_WADDR` write appears on the DRAM bus. It clears on `start`.
- Reset (any time, including mid-layer): state IDLE, buffer emptied, `starve_cnt`=0, all outputs 0. In-flight reads are dropped, so no `rd_valid` follows.

## Timing
- Read: `rd_gnt` in cycle t → `DRAMreadEn`=1 with `DRAMreadAddr`=`rd_addr` in cycle t+1. DRAM drives on the negedge of t+1. `rd_valid`=1 with `rd_data` in cycle t+2. Latency 2, throughput 1 per cycle.
- Write: push in cycle t with an empty buffer and no read contention → `DRAMwriteEn` in cycle t+1.
- DRAM command registers are 1-cycle pulses. Their enables are 0 when idle, and address/data hold their last value.

## Structure
- Package `cnn_acc_pkg`: `ADDR_W`, `DATA_W`, `arb_state_t` {IDLE, RUN, DONE}.
- Sub-module `wb_fifo`: synchronous FIFO with DEPTH and WIDTH=ADDR_W+DATA_W parameters, `push/pop/full/empty`, async active-low reset.

## Test plan
- Reset, `start`, read `rd_addr`=5 with mem[5]=64'hA5 → `DRAMreadEn`/addr 5 at t+1, `rd_valid` with 64'hA5 at t+2.
- Continuous `rd_req` plus one write (addr 3) → 8 reads granted, 9th cycle issues the write, `rd_gnt`=0 that cycle.
- 5 back-to-back writes with `rd_req`=1 → `wr_ready` drops after 4 are buffered. Buffer full forces writes. All 5 reach DRAM in order.
- Write stream addr 0..24 → `done` is 1 the cycle after addr 24 issues. `rd_gnt`=0 thereafter. `start` clears `done`.
- Assert `rst_n`=0 mid-layer with 3 buffered writes and a read in flight → all outputs 0 immediately, no `rd_valid`, and no DRAM writes after release.
- Randomized `rd_req`/`wr_req` for 10k cycles → never both DRAM enables high. Writes match push order, reads match scoreboard.
